// File: rtl/cpu64_l1_repl_if.sv
// -----------------------------------------------------------------------------
// cpu64_l1_repl_if
// Bundles the touch and victim-request/response signals that pass between the
// L1 miss/refill controller (master) and the replacement-policy unit (slave).
//
// Signals:
//   access_i      touch strobe (hit or fill) for access_set_i / access_way_i
//   access_set_i  set being touched
//   access_way_i  way being touched
//   vreq_i        victim request for vreq_set_i
//   vreq_set_i    set the victim is wanted for
//   valid_i       valid mask of vreq_set_i, sampled with vreq_i
//   lock_i        1 = way may not be chosen, sampled with vreq_i
//   vvalid_o      one-cycle pulse, victim_o / vnone_o are valid
//   victim_o      selected victim way
//   vnone_o       every way was locked, victim_o is 0
// -----------------------------------------------------------------------------
interface cpu64_l1_repl_if #(
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 8
) ();
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic                access_i;
    logic [SET_W-1:0]    access_set_i;
    logic [WAY_W-1:0]    access_way_i;
    logic                vreq_i;
    logic [SET_W-1:0]    vreq_set_i;
    logic [NUM_WAYS-1:0] valid_i;
    logic [NUM_WAYS-1:0] lock_i;
    logic                vvalid_o;
    logic [WAY_W-1:0]    victim_o;
    logic                vnone_o;

    modport master (
        output access_i, access_set_i, access_way_i,
        output vreq_i, vreq_set_i, valid_i, lock_i,
        input  vvalid_o, victim_o, vnone_o
    );

    modport slave (
        input  access_i, access_set_i, access_way_i,
        input  vreq_i, vreq_set_i, valid_i, lock_i,
        output vvalid_o, victim_o, vnone_o
    );
endinterface

// File: rtl/cpu64_l1_repl.sv
// -----------------------------------------------------------------------------
// cpu64_l1_repl
// L1 replacement-policy unit with configurable sets/ways. Per set it keeps a
// heap-ordered tree-PLRU vector and a round-robin pointer; a single global
// 16-bit Galois LFSR provides the random start point. Victim selection honours
// a per-way lock mask and prefers the lowest invalid unlocked way. After reset
// or a flush, an init sweep clears one set per cycle while busy_o is high.
//
// Ports:
//   clk_i    clock, all state changes on the rising edge
//   rst_i    synchronous active-high reset
//   mode_i   0 = PLRU, 1 = round-robin, 2 = LFSR, 3 = PLRU
//   flush_i  one-cycle pulse, restarts the init sweep
//   busy_o   high while the init sweep runs
//   bus      touch / victim handshake (slave side of cpu64_l1_repl_if)
// -----------------------------------------------------------------------------
module cpu64_l1_repl #(
    parameter int          NUM_SETS  = 64,
    parameter int          NUM_WAYS  = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [1:0]     mode_i,
    input  logic           flush_i,
    output logic           busy_o,
    cpu64_l1_repl_if.slave bus
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int NODES = NUM_WAYS - 1;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e              state_q;
    logic [SET_W-1:0]    sweep_q;
    logic [15:0]         lfsr_q;
    logic [15:0]         lfsr_next;
    logic                busy_q;
    logic                vvalid_q;
    logic [WAY_W-1:0]    victim_q;
    logic                vnone_q;

    // NOTE: the per-set arrays are deliberately not reset; the init sweep
    // clears them one set per cycle, which keeps them mappable to RAM.
    logic [NODES-1:0]    plru_q [NUM_SETS];
    logic [WAY_W-1:0]    rr_q   [NUM_SETS];

    logic [NUM_WAYS-1:0] elig;
    logic [NUM_WAYS-1:0] free;
    logic                sel_none;
    logic [WAY_W-1:0]    sel_way;

    // 1 if any bit of m in [lo, lo+len) is set.
    function automatic logic any_in_range(input logic [NUM_WAYS-1:0] m,
                                          input int lo, input int len);
        logic r;
        r = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w >= lo && w < lo + len) r = r | m[w];
        end
        return r;
    endfunction

    // First set bit of m scanning upward from start, wrapping modulo NUM_WAYS.
    function automatic logic [WAY_W-1:0] scan_from(input logic [NUM_WAYS-1:0] m,
                                                   input logic [WAY_W-1:0] start);
        logic [WAY_W-1:0] way;
        logic [WAY_W-1:0] idx;
        logic             found;
        way   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            idx = start + WAY_W'(k);
            if (!found && m[idx]) begin
                way   = idx;
                found = 1'b1;
            end
        end
        return way;
    endfunction

    // Follow the LRU pointers, diverting to the sibling whenever the indicated
    // subtree holds no eligible way. The caller guarantees m is nonzero.
    function automatic logic [WAY_W-1:0] plru_walk(input logic [NODES-1:0] bits,
                                                   input logic [NUM_WAYS-1:0] m);
        logic [NUM_WAYS-1:0] tree;
        logic [WAY_W-1:0]    node;
        logic                go_right;
        int                  base;
        int                  half;
        tree = {1'b0, bits};
        node = '0;
        base = 0;
        for (int l = 0; l < WAY_W; l++) begin
            half = NUM_WAYS >> (l + 1);
            if (tree[node]) go_right = any_in_range(m, base + half, half);
            else            go_right = !any_in_range(m, base, half);
            if (go_right) base = base + half;
            node = (node << 1) + (go_right ? WAY_W'(2) : WAY_W'(1));
        end
        return WAY_W'(base);
    endfunction

    // Point every node on the path to way away from it (bit 0 = left is LRU).
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WAY_W-1:0] way);
        logic [NUM_WAYS-1:0] tree;
        logic [WAY_W-1:0]    node;
        logic                dir;
        tree = {1'b0, bits};
        node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            dir        = way[WAY_W-1-l];
            tree[node] = ~dir;
            node       = (node << 1) + (dir ? WAY_W'(2) : WAY_W'(1));
        end
        return tree[NODES-1:0];
    endfunction

    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    // Selection uses the state as it stands before the edge, so a touch to the
    // same set in the same cycle is not seen by this request.
    always_comb begin
        elig     = ~bus.lock_i;
        free     = elig & ~bus.valid_i;
        sel_none = (elig == '0);
        sel_way  = '0;
        if (!sel_none) begin
            if (free != '0) begin
                sel_way = scan_from(free, '0);
            end else begin
                case (mode_i)
                    2'd1:    sel_way = scan_from(elig, rr_q[bus.vreq_set_i]);
                    2'd2:    sel_way = scan_from(elig, lfsr_q[WAY_W-1:0]);
                    default: sel_way = plru_walk(plru_q[bus.vreq_set_i], elig);
                endcase
            end
        end
    end

    // NOTE: all state here is sequential and uses non-blocking assignments, so
    // every read in this block sees the pre-edge value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_INIT;
            sweep_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            busy_q   <= 1'b1;
            vvalid_q <= 1'b0;
            victim_q <= '0;
            vnone_q  <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_next;
            vvalid_q <= 1'b0;
            if (flush_i) begin
                state_q <= ST_INIT;
                sweep_q <= '0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        plru_q[sweep_q] <= '0;
                        rr_q[sweep_q]   <= '0;
                        sweep_q         <= sweep_q + 1'b1;
                        if (sweep_q == SET_W'(NUM_SETS - 1)) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (bus.access_i) begin
                            plru_q[bus.access_set_i] <=
                                plru_touch(plru_q[bus.access_set_i], bus.access_way_i);
                        end
                        if (bus.vreq_i) begin
                            vvalid_q <= 1'b1;
                            victim_q <= sel_way;
                            vnone_q  <= sel_none;
                            if (!sel_none) rr_q[bus.vreq_set_i] <= sel_way + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign busy_o       = busy_q;
    assign bus.vvalid_o = vvalid_q;
    assign bus.victim_o = victim_q;
    assign bus.vnone_o  = vnone_q;
endmodule

// File: tb/tb_cpu64_l1_repl.sv
// -----------------------------------------------------------------------------
// tb_cpu64_l1_repl
// Self-checking bench for cpu64_l1_repl with default parameters. Each driven
// cycle pushes the expected response into a scoreboard queue; after the next
// rising edge the entry is popped and compared with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_cpu64_l1_repl;
    localparam int          NUM_SETS = 64;
    localparam int          NUM_WAYS = 8;
    localparam logic [15:0] SEED     = 16'hACE1;

    typedef struct {
        logic vld;
        logic none;
        int   way;
    } resp_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] mode_i;
    logic       flush_i;
    logic       busy_o;

    cpu64_l1_repl_if #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) bus ();

    cpu64_l1_repl #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS),
        .LFSR_SEED(SEED)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .mode_i (mode_i),
        .flush_i(flush_i),
        .busy_o (busy_o),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    resp_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference LFSR: taps from exponents 14, 13, 11 and the x^16 feedback.
    logic [15:0] m_lfsr;
    always @(posedge clk_i) begin
        if (rst_i) m_lfsr <= SEED;
        else       m_lfsr <= (m_lfsr >> 1) ^ ({16{m_lfsr[0]}} & 16'hB400);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic vld, input logic none, input int way);
        resp_t e;
        e.vld  = vld;
        e.none = none;
        e.way  = way;
        exp_q.push_back(e);
    endtask

    task automatic req(input int set, input logic [7:0] valid, input logic [7:0] lock,
                       input int exp_way, input logic exp_none);
        bus.vreq_i     = 1'b1;
        bus.vreq_set_i = 6'(set);
        bus.valid_i    = valid;
        bus.lock_i     = lock;
        push(1'b1, exp_none, exp_way);
    endtask

    // Request that the DUT must ignore (busy or in reset).
    task automatic req_ignored(input int set);
        bus.vreq_i     = 1'b1;
        bus.vreq_set_i = 6'(set);
        bus.valid_i    = 8'h00;
        bus.lock_i     = 8'h00;
        push(1'b0, 1'b0, 0);
    endtask

    task automatic noreq();
        bus.vreq_i = 1'b0;
        push(1'b0, 1'b0, 0);
    endtask

    task automatic tick(input string tag);
        resp_t e;
        @(posedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, ".vvalid"}, 32'(bus.vvalid_o), 32'(e.vld));
            if (e.vld) begin
                check({tag, ".victim"}, 32'(bus.victim_o), e.way);
                check({tag, ".vnone"},  32'(bus.vnone_o),  32'(e.none));
            end
        end
    endtask

    task automatic access(input int set, input int way);
        bus.access_i     = 1'b1;
        bus.access_set_i = 6'(set);
        bus.access_way_i = 3'(way);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        int rr_exp[8] = '{1, 2, 3, 4, 5, 6, 7, 1};

        rst_i            = 1'b1;
        mode_i           = 2'd0;
        flush_i          = 1'b0;
        bus.access_i     = 1'b0;
        bus.access_set_i = '0;
        bus.access_way_i = '0;
        bus.vreq_i       = 1'b0;
        bus.vreq_set_i   = '0;
        bus.valid_i      = '0;
        bus.lock_i       = '0;

        // Reset state, then busy for exactly NUM_SETS cycles; requests ignored.
        noreq(); tick("rst0");
        noreq(); tick("rst1");
        check("rst.busy",   32'(busy_o),       1);
        check("rst.victim", 32'(bus.victim_o), 0);
        check("rst.vnone",  32'(bus.vnone_o),  0);
        rst_i = 1'b0;
        cnt   = 0;
        while (busy_o && cnt < 200) begin
            if (cnt[0]) req_ignored(cnt % NUM_SETS);
            else        noreq();
            tick("init");
            cnt++;
        end
        check("init.busy_len", cnt, NUM_SETS);

        // Flush at init cycle 30 restarts the full sweep.
        rst_i = 1'b1;
        noreq(); tick("rst2");
        rst_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            noreq(); tick("pre_flush");
        end
        check("pre_flush.busy", 32'(busy_o), 1);
        flush_i = 1'b1;
        noreq(); tick("flush");
        flush_i = 1'b0;
        cnt = 0;
        while (busy_o && cnt < 200) begin
            req_ignored(7);
            tick("reinit");
            cnt++;
        end
        check("flush.busy_len", cnt, NUM_SETS);

        // Invalid ways are preferred, lowest index first.
        mode_i = 2'd0;
        req(9, 8'hFB, 8'h00, 2, 1'b0); tick("inv_fb");
        req(9, 8'h00, 8'h00, 0, 1'b0); tick("inv_00");
        noreq();                       tick("drop");

        // PLRU walk with lock masking.
        for (int w = 0; w < NUM_WAYS; w++) begin
            access(5, w);
            noreq();
            tick("touch");
        end
        bus.access_i = 1'b0;
        req(5, 8'hFF, 8'h00, 0, 1'b0); tick("plru_l00");
        req(5, 8'hFF, 8'h03, 2, 1'b0); tick("plru_l03");
        req(5, 8'hFF, 8'h0F, 4, 1'b0); tick("plru_l0f");
        req(5, 8'hFF, 8'hFF, 0, 1'b1); tick("plru_lff");

        // Same-cycle touch is invisible to the request, visible to the next.
        access(5, 0);
        req(5, 8'hFF, 8'h00, 0, 1'b0); tick("plru_old");
        bus.access_i = 1'b0;
        req(5, 8'hFF, 8'h00, 4, 1'b0); tick("plru_new");

        // Mode 3 behaves as PLRU on the same state.
        mode_i = 2'd3;
        req(5, 8'hFF, 8'h00, 4, 1'b0); tick("mode3");

        // Round-robin back-to-back with way 0 locked.
        mode_i = 2'd1;
        for (int i = 0; i < 8; i++) begin
            req(3, 8'hFF, 8'h01, rr_exp[i], 1'b0);
            tick("rr");
        end
        noreq(); tick("rr_drop");

        // LFSR mode: start index from the running LFSR.
        mode_i = 2'd2;
        for (int i = 0; i < 10; i++) begin
            req(7, 8'hFF, 8'h00, int'(m_lfsr[2:0]), 1'b0);
            tick("lfsr");
            if (i == 4) begin
                noreq(); tick("lfsr_gap");
            end
        end
        for (int i = 0; i < 6; i++) begin
            req(7, 8'hFF, 8'hFE, 0, 1'b0);
            tick("lfsr_lock");
        end

        // Reset aborts a response that would otherwise be issued.
        req(7, 8'hFF, 8'hFE, 0, 1'b0); tick("pre_rst");
        rst_i = 1'b1;
        req_ignored(7); tick("rst_abort");
        check("rst_abort.busy", 32'(busy_o), 1);
        rst_i = 1'b0;
        noreq(); tick("post_rst");

        check("sb.drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
